ula_driver: RTL and testbench
=============================

// Module: ula_driver
// PURPOSE
//  Initiator side of the 6-bit ULA port. Queues operation commands from a host and drives
//  A/B/operacao/modo into the ULA. Holds ULA inputs stable until the registered result and
//  flags settle, then captures them. Returns each result to the host on a valid/ready channel.
//  Sits between the host/control logic and a ULA instance. Also keeps operation statistics.
// PARAMETERS
//  FIFO_DEPTH   4   command queue entries (power of 2, >=2)
//  LATENCY      3   cycles ULA inputs are held before capture (ULA result reg + zero-flag lag)
//  CNT_W        16  width of statistics counters
// PORTS
//  clk            in   1      system clock
//  reset_n        in   1      asynchronous active-low reset
//  cmd_valid      in   1      host command valid
//  cmd_ready      out  1      command accepted when cmd_valid & cmd_ready
//  cmd_a          in   6      operand A
//  cmd_b          in   6      operand B
//  cmd_op         in   3      operacao code
//  cmd_modo       in   1      1 = logic, 0 = arithmetic
//  rsp_valid      out  1      response valid
//  rsp_ready      in   1      host accepts response
//  rsp_resultado  out  6      captured o_resultado
//  rsp_overflow   out  1      captured o_overflow
//  rsp_zero       out  1      captured o_zero
//  ula_a/ula_b    out  6 each to ULA A/B
//  ula_operacao   out  3      to ULA operacao
//  ula_modo       out  1      to ULA modo
//  ula_reset      out  1      to ULA reset (active-high, synchronous at ULA)
//  ula_resultado  in   6      from ULA o_resultado
//  ula_overflow   in   1      from ULA o_overflow
//  ula_zero       in   1      from ULA o_zero
//  op_count       out  CNT_W  completed operations (wraps)
//  ovf_count      out  CNT_W  completed operations with overflow=1 (wraps)
// BEHAVIOUR
//  Reset (reset_n=0, async): FSM=IDLE, FIFO empty, all rsp_* = 0, ula_a/b/operacao/modo = 0,
//   op/ovf_count = 0, cmd_ready = 0. ula_reset = 1 while reset_n=0 and for 2 clk after release.
//   cmd_ready rises on the 3rd edge after reset release.
//  cmd_ready = !fifo_full & !ula_reset. A push while full is impossible (ready low).
//  FSM: IDLE -> ISSUE when FIFO non-empty; ISSUE pops head and registers ula_* (1 cycle).
//   ISSUE -> WAIT. WAIT counts LATENCY cycles with ula_* held constant.
//   WAIT -> CAPTURE. CAPTURE samples ula_resultado/overflow/zero into rsp_*, sets rsp_valid,
//   increments op_count (and ovf_count if overflow). CAPTURE -> RESP.
//   RESP holds rsp_* stable while rsp_valid & !rsp_ready.
//   On handshake: rsp_valid=0 and go to IDLE, or directly to ISSUE if FIFO non-empty.
//  Latency: cmd accepted at edge t into empty FIFO/IDLE -> rsp_valid at edge t+LATENCY+3
//   (t+6 by default).
//  Simultaneous pop (ISSUE) and push: both occur; occupancy unchanged.
//  One command in flight max; FIFO_DEPTH queued + 1 in flight = FIFO_DEPTH+1 outstanding.
//  ula_* keep the last issued values in IDLE/RESP (no toggling).
//  Counters wrap at 2**CNT_W-1 -> 0 silently.
//  Reset mid-operation: in-flight and queued commands discarded, no response emitted,
//   counters cleared.
// STRUCTURE
//  Package ula_pkg: typedef enum logic [2:0] ula_op_t (op codes), localparams
//   MODO_LOGICA=1'b1 / MODO_ARIT=1'b0, typedef struct packed ula_cmd_t {a,b,op,modo} (16 bits).
//  Sub-module ula_cmd_fifo: sync FIFO of ula_cmd_t, params DEPTH; push/pop/full/empty;
//   async active-low reset.
//  FSM, wait counter, response regs, and stat counters live in ula_driver.
// TESTING (bench pairs ula_driver with the ULA instance)
//  1. modo=0 op=000 A=5 B=3, rsp_ready=1 -> rsp_resultado=8, overflow=0, zero=0;
//     rsp_valid 6 cycles after accept.
//  2. modo=0 op=000 A=63 B=1 -> rsp_resultado=0, overflow=1, zero=1; ovf_count=1, op_count=1.
//  3. modo=1 op=000 A=6'h2A B=6'h15 -> rsp_resultado=0, overflow=0, zero=1;
//     then op=011 same operands -> 6'h3F, zero=0.
//  4. rsp_ready=0, push 7 commands back-to-back -> exactly 5 accepted, cmd_ready=0 after;
//     rsp_* stable. Release rsp_ready -> 5 responses in order, no loss/dup.
//  5. reset_n pulsed low during WAIT -> rsp_valid=0, counters=0, ula_reset high;
//     cmd_ready=1 on 3rd edge after release; new cmd A=1 B=1 op=000 -> resultado=2.
//  6. Push at the same edge as ISSUE pop with FIFO holding 1 entry -> occupancy stays 1;
//     both commands return in order.

Source files
------------

// File: rtl/ula_pkg.sv
// ---------------------------------------------------------------------------
// ula_pkg
// Shared types for the ULA initiator: operation codes, modo encodings, the
// 16-bit command record carried through the command queue, and the driver
// FSM state encoding.
// ---------------------------------------------------------------------------
package ula_pkg;

  // Operation codes. The meaning depends on modo: arithmetic name first,
  // logic name second.
  typedef enum logic [2:0] {
    OP_ADD_AND    = 3'b000,
    OP_SUB_NAND   = 3'b001,
    OP_INC_XOR    = 3'b010,
    OP_DEC_OR     = 3'b011,
    OP_PASSA_NOR  = 3'b100,
    OP_PASSA_XNOR = 3'b101,
    OP_PASSA_NOTA = 3'b110,
    OP_PASSA_PASS = 3'b111
  } ula_op_t;

  localparam logic MODO_LOGICA = 1'b1;
  localparam logic MODO_ARIT   = 1'b0;

  // One queued operation: {a, b, op, modo} = 6 + 6 + 3 + 1 bits.
  typedef struct packed {
    logic [5:0] a;
    logic [5:0] b;
    ula_op_t    op;
    logic       modo;
  } ula_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } drv_state_t;

endpackage

// File: rtl/ula_cmd_fifo.sv
// ---------------------------------------------------------------------------
// ula_cmd_fifo
// Synchronous first-word-fall-through queue of ula_cmd_t records.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push_i, din_i   write request and data (ignored when full)
//   pop_i           read request (ignored when empty)
//   dout_o          head entry, valid whenever empty_o is low
//   full_o/empty_o  occupancy status
// ---------------------------------------------------------------------------
module ula_cmd_fifo
  import ula_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push_i,
  input  ula_cmd_t din_i,
  input  logic     pop_i,
  output ula_cmd_t dout_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_C  = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  ula_cmd_t      mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          push_en_s;
  logic          pop_en_s;

  assign full_o    = (count_q == DEPTH_C);
  assign empty_o   = (count_q == {(AW+1){1'b0}});
  assign push_en_s = push_i & ~full_o;
  assign pop_en_s  = pop_i & ~empty_o;
  assign dout_o    = mem_q[rd_ptr_q];

  // Occupancy update; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_en_s, pop_en_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en_s) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop_en_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ula_driver.sv
// ---------------------------------------------------------------------------
// ula_driver
// Initiator for a 6-bit ULA. Host commands are queued, issued one at a time
// to the ULA, held for LATENCY cycles while the ULA's registered result and
// lagging zero flag settle, captured, and returned on a valid/ready channel.
// Also counts completed operations and those that overflowed.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_a/b/op/modo              command fields
//   rsp_valid/rsp_ready          response handshake
//   rsp_resultado/overflow/zero  captured ULA outputs
//   ula_a/b/operacao/modo        ULA operand/control inputs
//   ula_reset                    ULA synchronous reset (active high)
//   ula_resultado/overflow/zero  ULA outputs
//   op_count, ovf_count          wrapping statistics counters
// ---------------------------------------------------------------------------
module ula_driver
  import ula_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LATENCY    = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [5:0]       cmd_a,
  input  logic [5:0]       cmd_b,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_modo,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [5:0]       rsp_resultado,
  output logic             rsp_overflow,
  output logic             rsp_zero,
  output logic [5:0]       ula_a,
  output logic [5:0]       ula_b,
  output logic [2:0]       ula_operacao,
  output logic             ula_modo,
  output logic             ula_reset,
  input  logic [5:0]       ula_resultado,
  input  logic             ula_overflow,
  input  logic             ula_zero,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] ovf_count
);

  localparam int WAIT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LATENCY - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  drv_state_t        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [5:0]        ula_a_q, ula_a_d;
  logic [5:0]        ula_b_q, ula_b_d;
  ula_op_t           ula_op_q, ula_op_d;
  logic              ula_modo_q, ula_modo_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [5:0]        rsp_res_q, rsp_res_d;
  logic              rsp_ovf_q, rsp_ovf_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic [CNT_W-1:0]  op_cnt_q, op_cnt_d;
  logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;
  logic [1:0]        rst_hold_q, rst_hold_d;
  logic              ula_reset_q, ula_reset_d;

  ula_cmd_t          cmd_s;
  ula_cmd_t          fifo_head_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              fifo_pop_s;
  logic              fifo_push_s;

  // Commands are refused while the queue is full and while the ULA is still
  // being held in reset.
  assign cmd_ready   = ~fifo_full_s & ~ula_reset_q;
  assign fifo_push_s = cmd_valid & cmd_ready;

  assign rsp_valid     = rsp_valid_q;
  assign rsp_resultado = rsp_res_q;
  assign rsp_overflow  = rsp_ovf_q;
  assign rsp_zero      = rsp_zero_q;
  assign ula_a         = ula_a_q;
  assign ula_b         = ula_b_q;
  assign ula_operacao  = ula_op_q;
  assign ula_modo      = ula_modo_q;
  assign ula_reset     = ula_reset_q;
  assign op_count      = op_cnt_q;
  assign ovf_count     = ovf_cnt_q;

  // Pack the host command fields into a queue record.
  always_comb begin
    cmd_s.a    = cmd_a;
    cmd_s.b    = cmd_b;
    cmd_s.op   = ula_op_t'(cmd_op);
    cmd_s.modo = cmd_modo;
  end

  ula_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (fifo_push_s),
    .din_i   (cmd_s),
    .pop_i   (fifo_pop_s),
    .dout_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // ULA reset stretch: stays high through the first two edges after release
  // and drops on the third, so the ULA sees at least two synchronous resets.
  always_comb begin
    if (rst_hold_q != 2'd0) begin
      rst_hold_d = rst_hold_q - 2'd1;
    end else begin
      rst_hold_d = 2'd0;
    end
    ula_reset_d = (rst_hold_d != 2'd0);
  end

  // Reset-stretch registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_hold_q  <= 2'd3;
      ula_reset_q <= 1'b1;
    end else begin
      rst_hold_q  <= rst_hold_d;
      ula_reset_q <= ula_reset_d;
    end
  end

  // FSM next state plus datapath next values. ULA inputs change only in
  // ISSUE, so they are stable through WAIT/CAPTURE and keep the last issued
  // command while idle or waiting on the host.
  always_comb begin
    state_d     = state_q;
    fifo_pop_s  = 1'b0;
    wait_cnt_d  = wait_cnt_q;
    ula_a_d     = ula_a_q;
    ula_b_d     = ula_b_q;
    ula_op_d    = ula_op_q;
    ula_modo_d  = ula_modo_q;
    rsp_valid_d = rsp_valid_q;
    rsp_res_d   = rsp_res_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_zero_d  = rsp_zero_q;
    op_cnt_d    = op_cnt_q;
    ovf_cnt_d   = ovf_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        fifo_pop_s = 1'b1;
        ula_a_d    = fifo_head_s.a;
        ula_b_d    = fifo_head_s.b;
        ula_op_d   = fifo_head_s.op;
        ula_modo_d = fifo_head_s.modo;
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_CAPTURE;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
      end
      ST_CAPTURE: begin
        rsp_res_d   = ula_resultado;
        rsp_ovf_d   = ula_overflow;
        rsp_zero_d  = ula_zero;
        rsp_valid_d = 1'b1;
        op_cnt_d    = op_cnt_q + CNT_ONE;
        if (ula_overflow) begin
          ovf_cnt_d = ovf_cnt_q + CNT_ONE;
        end else begin
          ovf_cnt_d = ovf_cnt_q;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty_s) begin
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      ula_a_q     <= 6'd0;
      ula_b_q     <= 6'd0;
      ula_op_q    <= OP_ADD_AND;
      ula_modo_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_res_q   <= 6'd0;
      rsp_ovf_q   <= 1'b0;
      rsp_zero_q  <= 1'b0;
      op_cnt_q    <= '0;
      ovf_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      ula_a_q     <= ula_a_d;
      ula_b_q     <= ula_b_d;
      ula_op_q    <= ula_op_d;
      ula_modo_q  <= ula_modo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_res_q   <= rsp_res_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_zero_q  <= rsp_zero_d;
      op_cnt_q    <= op_cnt_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

endmodule

// File: tb/tb_ula_driver.sv
// ---------------------------------------------------------------------------
// tb_ula_driver
// Bench for ula_driver paired with a behavioural ULA (registered result and
// overflow, zero flag lagging one more cycle, synchronous active-high reset).
// ---------------------------------------------------------------------------
module tb_ula_driver;
  import ula_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [5:0]  cmd_a = 6'd0;
  logic [5:0]  cmd_b = 6'd0;
  logic [2:0]  cmd_op = 3'd0;
  logic        cmd_modo = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [5:0]  rsp_resultado;
  logic        rsp_overflow;
  logic        rsp_zero;
  logic [5:0]  ula_a, ula_b;
  logic [2:0]  ula_operacao;
  logic        ula_modo;
  logic        ula_reset;
  logic [5:0]  ula_res_q = 6'd0;
  logic        ula_ovf_q = 1'b0;
  logic        ula_zero_q = 1'b0;
  logic [15:0] op_count, ovf_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_op   = 0;
  int exp_ovf  = 0;

  always #5 clk = ~clk;

  ula_driver dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_a         (cmd_a),
    .cmd_b         (cmd_b),
    .cmd_op        (cmd_op),
    .cmd_modo      (cmd_modo),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_resultado (rsp_resultado),
    .rsp_overflow  (rsp_overflow),
    .rsp_zero      (rsp_zero),
    .ula_a         (ula_a),
    .ula_b         (ula_b),
    .ula_operacao  (ula_operacao),
    .ula_modo      (ula_modo),
    .ula_reset     (ula_reset),
    .ula_resultado (ula_res_q),
    .ula_overflow  (ula_ovf_q),
    .ula_zero      (ula_zero_q),
    .op_count      (op_count),
    .ovf_count     (ovf_count)
  );

  // Behavioural ULA: {overflow/carry/borrow, result}
  function automatic logic [6:0] ula_f(input logic [5:0] a, input logic [5:0] b,
                                       input logic [2:0] op, input logic m);
    logic [6:0] r;
    r = 7'd0;
    if (m == MODO_ARIT) begin
      case (op)
        3'b000:  r = {1'b0, a} + {1'b0, b};
        3'b001:  r = {1'b0, a} - {1'b0, b};
        3'b010:  r = {1'b0, a} + 7'd1;
        3'b011:  r = {1'b0, a} - 7'd1;
        default: r = {1'b0, a};
      endcase
    end else begin
      case (op)
        3'b000:  r = {1'b0, a & b};
        3'b001:  r = {1'b0, ~(a & b)};
        3'b010:  r = {1'b0, a ^ b};
        3'b011:  r = {1'b0, a | b};
        3'b100:  r = {1'b0, ~(a | b)};
        3'b101:  r = {1'b0, ~(a ^ b)};
        3'b110:  r = {1'b0, ~a};
        default: r = {1'b0, a};
      endcase
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (ula_reset) begin
      ula_res_q  <= 6'd0;
      ula_ovf_q  <= 1'b0;
      ula_zero_q <= 1'b0;
    end else begin
      {ula_ovf_q, ula_res_q} <= ula_f(ula_a, ula_b, ula_operacao, ula_modo);
      ula_zero_q             <= (ula_res_q == 6'd0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out", name);
  endtask

  // Entered and left at a negedge; ok=1 when the command was accepted.
  task automatic send_cmd(input logic [5:0] a, input logic [5:0] b,
                          input logic [2:0] op, input logic m, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_modo = m; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready) begin
      @(posedge clk);
      ok = 1'b1;
    end else begin
      fail_timeout("cmd_accept");
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Counts negedges until rsp_valid is seen.
  task automatic wait_rsp(output int cyc, output bit ok);
    cyc = 0;
    while (!rsp_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    ok = rsp_valid;
    if (!ok) fail_timeout("rsp_wait");
  endtask

  // Hold reset, check reset values, release, check ready/ULA-reset timing.
  task automatic reset_and_check();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rsp",  32'({rsp_valid, rsp_resultado, rsp_overflow, rsp_zero}), 32'd0);
    check("rst_ula",  32'({ula_a, ula_b, ula_operacao, ula_modo}), 32'd0);
    check("rst_cnt",  32'({op_count, ovf_count}), 32'd0);
    check("rst_rdy",  32'(cmd_ready), 32'd0);
    check("rst_ulareset", 32'(ula_reset), 32'd1);
    reset_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("rdy_edge%0d", k), 32'(cmd_ready), (k == 3) ? 32'd1 : 32'd0);
      check($sformatf("ulareset_edge%0d", k), 32'(ula_reset), (k < 3) ? 32'd1 : 32'd0);
    end
    exp_op  = 0;
    exp_ovf = 0;
  endtask

  typedef struct {
    logic [5:0] a;
    logic [5:0] b;
    logic [2:0] op;
    logic       modo;
    logic [5:0] res;
    logic       ovf;
    logic       zero;
  } vec_t;

  vec_t vecs [6];
  logic [5:0] exp_q [$];
  logic [5:0] e;

  initial begin
    bit ok;
    int cyc;
    int acc;
    int got;
    int n;
    bit stable;
    logic [8:0] saved;

    vecs[0] = '{6'd5,  6'd3,  3'b000, 1'b0, 6'd8,  1'b0, 1'b0};
    vecs[1] = '{6'd63, 6'd1,  3'b000, 1'b0, 6'd0,  1'b1, 1'b1};
    vecs[2] = '{6'h2A, 6'h15, 3'b000, 1'b1, 6'h00, 1'b0, 1'b1};
    vecs[3] = '{6'h2A, 6'h15, 3'b011, 1'b1, 6'h3F, 1'b0, 1'b0};
    vecs[4] = '{6'd10, 6'd3,  3'b001, 1'b0, 6'd7,  1'b0, 1'b0};
    vecs[5] = '{6'd3,  6'd5,  3'b001, 1'b0, 6'h3E, 1'b1, 1'b0};

    reset_and_check();

    // Table-driven single operations from idle.
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_cmd(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].modo, ok);
      wait_rsp(cyc, ok);
      if (ok) begin
        check($sformatf("v%0d_latency", i), 32'(cyc), 32'd6);
        check($sformatf("v%0d_res", i), 32'(rsp_resultado), 32'(vecs[i].res));
        check($sformatf("v%0d_ovf", i), 32'(rsp_overflow), 32'(vecs[i].ovf));
        check($sformatf("v%0d_zero", i), 32'(rsp_zero), 32'(vecs[i].zero));
      end
      @(negedge clk);
      exp_op++;
      if (vecs[i].ovf) exp_ovf++;
      check($sformatf("v%0d_valid_drop", i), 32'(rsp_valid), 32'd0);
      check($sformatf("v%0d_op_count", i), 32'(op_count), 32'(exp_op));
      check($sformatf("v%0d_ovf_count", i), 32'(ovf_count), 32'(exp_ovf));
    end

    // Back-pressure: 7 back-to-back pushes with the host stalled.
    rsp_ready = 1'b0;
    acc = 0;
    exp_q.delete();
    for (int i = 0; i < 7; i++) begin
      cmd_a = 6'(i + 1); cmd_b = 6'(2 * i); cmd_op = 3'b000; cmd_modo = 1'b0;
      cmd_valid = 1'b1;
      if (cmd_ready) begin
        acc++;
        e = 6'(3 * i + 1);
        exp_q.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("bp_accepted", 32'(acc), 32'd5);
    check("bp_ready_low", 32'(cmd_ready), 32'd0);
    wait_rsp(cyc, ok);
    saved = {rsp_resultado, rsp_overflow, rsp_zero, rsp_valid};
    stable = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if ({rsp_resultado, rsp_overflow, rsp_zero, rsp_valid} !== saved) stable = 1'b0;
    end
    check("bp_rsp_stable", 32'(stable), 32'd1);
    check("bp_first_res", 32'(saved[8:3]), 32'd1);
    check("bp_ula_held", 32'({ula_a, ula_b}), 32'({6'd1, 6'd0}));
    rsp_ready = 1'b1;
    got = 0;
    n = 0;
    while (got < 5 && n < 200) begin
      if (rsp_valid) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check($sformatf("bp_rsp%0d", got), 32'(rsp_resultado), 32'(e));
        end
        got++;
      end
      @(negedge clk);
      n++;
    end
    check("bp_drain_count", 32'(got), 32'd5);
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) stable = 1'b0;
    end
    check("bp_no_extra", 32'(stable), 32'd1);
    exp_op += 5;
    check("bp_op_count", 32'(op_count), 32'(exp_op));

    // Push coinciding with the ISSUE pop while one entry is queued.
    cmd_a = 6'd7; cmd_b = 6'd8; cmd_op = 3'b000; cmd_modo = 1'b0; cmd_valid = 1'b1;
    @(posedge clk);              // accept edge t (FIFO 0 -> 1)
    @(negedge clk);
    cmd_valid = 1'b0;
    check("sim_occ_before", 32'(dut.u_fifo.count_q), 32'd1);
    @(posedge clk);              // t+1: IDLE -> ISSUE
    @(negedge clk);
    cmd_a = 6'd20; cmd_b = 6'd30; cmd_valid = 1'b1;
    check("sim_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);              // t+2: pop and push together
    @(negedge clk);
    cmd_valid = 1'b0;
    check("sim_occ_after", 32'(dut.u_fifo.count_q), 32'd1);
    check("sim_issued", 32'(ula_a), 32'd7);
    exp_q.delete();
    e = 6'd15; exp_q.push_back(e);
    e = 6'd50; exp_q.push_back(e);
    got = 0;
    n = 0;
    while (got < 2 && n < 100) begin
      if (rsp_valid) begin
        e = exp_q.pop_front();
        check($sformatf("sim_rsp%0d", got), 32'(rsp_resultado), 32'(e));
        got++;
      end
      @(negedge clk);
      n++;
    end
    check("sim_count", 32'(got), 32'd2);

    // Reset pulsed while an operation is in WAIT.
    send_cmd(6'd9, 6'd9, 3'b000, 1'b0, ok);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_cnt", 32'({op_count, ovf_count}), 32'd0);
    check("mid_rst_ulareset", 32'(ula_reset), 32'd1);
    reset_and_check();
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) stable = 1'b0;
    end
    check("mid_rst_no_rsp", 32'(stable), 32'd1);
    send_cmd(6'd1, 6'd1, 3'b000, 1'b0, ok);
    wait_rsp(cyc, ok);
    if (ok) begin
      check("post_rst_latency", 32'(cyc), 32'd6);
      check("post_rst_res", 32'(rsp_resultado), 32'd2);
    end
    @(negedge clk);
    check("post_rst_op_count", 32'(op_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
